// File: rtl/muldiv_unit.sv
// Iterative unsigned MULTU/DIVU unit with architectural HI/LO registers.
// One multiplier/quotient bit per cycle; WIDTH iterations per operation.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned AW = 2 * WIDTH;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_DIVU  = 2'b01;
   localparam logic [1:0] OP_MTHI  = 2'b10;
   localparam logic [1:0] OP_MTLO  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MUL  = 2'b01,
      S_DIV  = 2'b10
   } state_t;

   state_t           state, state_n;
   logic [AW-1:0]    acc, acc_n;       // MUL: {partial upper, multiplier}; DIV: {remainder, quotient}
   logic [WIDTH-1:0] opnd, opnd_n;     // multiplicand or divisor
   logic [CW-1:0]    cnt, cnt_n;
   logic             busy_n, done_n, div0_n;
   logic [WIDTH-1:0] hi_n, lo_n;

   logic [WIDTH:0]   mul_sum;
   logic [AW-1:0]    mul_next;
   logic [WIDTH:0]   div_t;
   logic             div_ge;
   logic [WIDTH-1:0] div_rem;
   logic [AW-1:0]    div_next;
   logic             last_iter;

   // Single shift-add and restoring-subtract step on the working register
   always_comb begin
      mul_sum  = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      mul_next = {mul_sum, acc[WIDTH-1:1]};
      div_t    = {acc[AW-1:WIDTH], acc[WIDTH-1]};
      div_ge   = (div_t >= {1'b0, opnd});
      div_rem  = div_ge ? WIDTH'(div_t - {1'b0, opnd}) : div_t[WIDTH-1:0];
      div_next = {div_rem, acc[WIDTH-2:0], div_ge};
      last_iter = (cnt == CW'(WIDTH - 1));
   end

   // Next-state, datapath and output decode
   always_comb begin
      state_n = state;
      acc_n   = acc;
      opnd_n  = opnd;
      cnt_n   = cnt;
      done_n  = 1'b0;
      div0_n  = 1'b0;
      hi_n    = hi;
      lo_n    = lo;
      case (state)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_MULTU: begin
                     state_n = S_MUL;
                     acc_n   = {{WIDTH{1'b0}}, src_b};
                     opnd_n  = src_a;
                     cnt_n   = '0;
                  end
                  OP_DIVU: begin
                     state_n = S_DIV;
                     acc_n   = {{WIDTH{1'b0}}, src_a};
                     opnd_n  = src_b;
                     cnt_n   = '0;
                  end
                  OP_MTHI: hi_n = src_a;
                  OP_MTLO: lo_n = src_a;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            acc_n = mul_next;
            cnt_n = cnt + CW'(1);
            if (last_iter) begin
               state_n      = S_IDLE;
               done_n       = 1'b1;
               {hi_n, lo_n} = mul_next;
            end
         end
         S_DIV: begin
            acc_n = div_next;
            cnt_n = cnt + CW'(1);
            if (last_iter) begin
               state_n      = S_IDLE;
               done_n       = 1'b1;
               div0_n       = (opnd == '0);
               {hi_n, lo_n} = div_next;
            end
         end
         default: state_n = S_IDLE;
      endcase
      busy_n = (state_n != S_IDLE);
   end

   // State, working registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         acc   <= '0;
         opnd  <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         div0  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         opnd  <= opnd_n;
         cnt   <= cnt_n;
         busy  <= busy_n;
         done  <= done_n;
         div0  <= div0_n;
         hi    <= hi_n;
         lo    <= lo_n;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against a cycle-level behavioural model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        busy, done, div0;
   logic [31:0] hi, lo;

   int errors = 0;
   int checks = 0;
   bit checking = 1'b0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b),
      .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: operations take 32 cycles, result from plain arithmetic
   logic        m_busy = 0, m_done = 0, m_div0 = 0, m_dz = 0;
   logic [31:0] m_hi = 0, m_lo = 0, m_rhi = 0, m_rlo = 0;
   int          m_left = 0;
   logic [63:0] prod;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_done = 0; m_div0 = 0; m_hi = 0; m_lo = 0; m_left = 0;
      end else begin
         m_done = 0;
         m_div0 = 0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 0; m_done = 1; m_div0 = m_dz;
               m_hi = m_rhi; m_lo = m_rlo;
            end
         end else if (start) begin
            case (op)
               2'b00: begin
                  prod = 64'(src_a) * 64'(src_b);
                  m_rhi = prod[63:32]; m_rlo = prod[31:0];
                  m_dz = 0; m_busy = 1; m_left = 32;
               end
               2'b01: begin
                  if (src_b == 0) begin
                     m_rlo = 32'hFFFF_FFFF; m_rhi = src_a; m_dz = 1;
                  end else begin
                     m_rlo = src_a / src_b; m_rhi = src_a % src_b; m_dz = 0;
                  end
                  m_busy = 1; m_left = 32;
               end
               2'b10: m_hi = src_a;
               default: m_lo = src_a;
            endcase
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (checking) begin
         chk("busy", 64'(busy), 64'(m_busy));
         chk("done", 64'(done), 64'(m_done));
         chk("div0", 64'(div0), 64'(m_div0));
         chk("hi",   64'(hi),   64'(m_hi));
         chk("lo",   64'(lo),   64'(m_lo));
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(negedge clk);
      start = 1'b0;
      src_a = $urandom; src_b = $urandom; op = 2'($urandom);
   endtask

   // Waits (bounded) for done; counts busy cycles seen on the way
   task automatic wait_done(output int nb);
      bit found = 0;
      nb = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin found = 1; break; end
         if (busy) nb++;
         @(negedge clk);
      end
      chk("done_seen", 64'(found), 64'd1);
   endtask

   int nb;

   initial begin
      // Reset
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checking = 1'b1;
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_div0", 64'(div0), 64'd0);

      // MULTU max
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(nb);
      chk("mul_max_busy_cycles", 64'(nb), 64'd32);
      chk("mul_max_hi", 64'(hi), 64'hFFFF_FFFE);
      chk("mul_max_lo", 64'(lo), 64'h1);
      @(negedge clk);
      chk("mul_max_done_pulse", 64'(done), 64'd0);

      // DIVU 100/7 with inputs scrambled after start
      issue(2'b01, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      src_a = 32'd0;
      wait_done(nb);
      chk("div_busy_cycles", 64'(nb + 3), 64'd32);
      chk("div_lo", 64'(lo), 64'd14);
      chk("div_hi", 64'(hi), 64'd2);

      // Divide by zero
      issue(2'b01, 32'd5, 32'd0);
      wait_done(nb);
      chk("dz_lo", 64'(lo), 64'hFFFF_FFFF);
      chk("dz_hi", 64'(hi), 64'd5);
      chk("dz_div0", 64'(div0), 64'd1);
      @(negedge clk);
      chk("dz_div0_next", 64'(div0), 64'd0);

      // Start while busy is ignored
      issue(2'b00, 32'd3, 32'd4);
      repeat (2) @(negedge clk);
      start = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done(nb);
      chk("busy_start_hi", 64'(hi), 64'd0);
      chk("busy_start_lo", 64'(lo), 64'd12);

      // Reset mid-operation aborts with no done
      issue(2'b00, $urandom, $urandom);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      repeat (30) begin
         @(negedge clk);
         chk("abort_no_done", 64'(done), 64'd0);
      end

      // MTHI then MTLO on consecutive cycles
      @(negedge clk);
      start = 1'b1; op = 2'b10; src_a = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
      chk("mthi_busy", 64'(busy), 64'd0);
      op = 2'b11; src_a = 32'h1234_5678;
      @(negedge clk);
      start = 1'b0;
      chk("mtlo_lo", 64'(lo), 64'h1234_5678);
      chk("mtlo_hi", 64'(hi), 64'hDEAD_BEEF);
      chk("mtlo_done", 64'(done), 64'd0);

      // Back-to-back: start during the done cycle
      issue(2'b01, $urandom, $urandom_range(1, 1000));
      wait_done(nb);
      start = 1'b1; op = 2'b00; src_a = 32'd2; src_b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", 64'(busy), 64'd1);
      wait_done(nb);
      chk("b2b_lo", 64'(lo), 64'd6);
      chk("b2b_hi", 64'(hi), 64'd0);

      // Randomized operations, some back-to-back
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  ro = 2'($urandom);
         logic [31:0] ra = $urandom;
         logic [31:0] rb;
         case ($urandom_range(0, 3))
            0: rb = 32'd0;
            1: rb = $urandom_range(1, 16);
            default: rb = $urandom;
         endcase
         issue(ro, ra, rb);
         if (ro[1] == 1'b0) wait_done(nb);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
